// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types, widths and op-priority decode for the PC sequencer
package pc_seq_pkg;

  localparam int PC_W  = 10;
  localparam int OFF_W = 8;

  typedef enum logic [1:0] {
    ST_RST,
    ST_RUN,
    ST_STALL,
    ST_HALTED
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_LOAD,
    OP_BRANCH,
    OP_JUMP,
    OP_HALT
  } op_e;

  // Highest-priority op class wins; lower op bits are ignored.
  function automatic op_e decode_op(input logic h, input logic j, input logic b, input logic l);
    if (h)      return OP_HALT;
    else if (j) return OP_JUMP;
    else if (b) return OP_BRANCH;
    else if (l) return OP_LOAD;
    else        return OP_NONE;
  endfunction

  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                    input logic [OFF_W-1:0] off);
    return pc + {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decode/memory inputs and PC control outputs of the sequencer
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int RETIRE_W = 16
) ();

  logic                instr_valid;
  logic                op_halt;
  logic                op_jump;
  logic                op_branch;
  logic                op_load;
  logic                zero_flag;
  logic [PC_W-1:0]     jmp_addr;
  logic [OFF_W-1:0]    br_offset;
  logic [PC_W-1:0]     pc;
  logic                mem_ack;

  logic                pc_init;
  logic                jump_en;
  logic                branch_en;
  logic                halt;
  logic [PC_W-1:0]     target;
  logic                mem_req;
  logic [RETIRE_W-1:0] retired;
  logic                seq_err;

  modport master (
    output instr_valid, op_halt, op_jump, op_branch, op_load, zero_flag,
           jmp_addr, br_offset, pc, mem_ack,
    input  pc_init, jump_en, branch_en, halt, target, mem_req, retired, seq_err
  );

  modport slave (
    input  instr_valid, op_halt, op_jump, op_branch, op_load, zero_flag,
           jmp_addr, br_offset, pc, mem_ack,
    output pc_init, jump_en, branch_en, halt, target, mem_req, retired, seq_err
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (inc && !(&q))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC control FSM (RST/RUN/STALL/HALTED) with retire counter
// Optional stall timeout and sticky seq_err enabled by defining PC_SEQ_TIMEOUT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int STALL_TIMEOUT = 16,
  parameter int RETIRE_W      = 16
) (
  input  logic         CLK,
  input  logic         init_n,
  pc_sequencer_if.slave bus
);

  state_e          state;
  state_e          state_nxt;
  op_e             op;
  logic            retire;
  logic            stall_to;
  logic            pc_init_c;
  logic            jump_en_c;
  logic            branch_en_c;
  logic            halt_c;
  logic            mem_req_c;
  logic [PC_W-1:0] target_c;

  assign op = decode_op(bus.op_halt, bus.op_jump, bus.op_branch, bus.op_load);

  always_ff @(posedge CLK) begin
    if (!init_n)
      state <= ST_RST;
    else
      state <= state_nxt;
  end

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             seq_err_q;

  assign stall_to = (state == ST_STALL) && !bus.mem_ack &&
                    (stall_cnt == CNT_W'(STALL_TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!init_n) begin
      stall_cnt <= '0;
      seq_err_q <= 1'b0;
    end else if (state == ST_STALL && !bus.mem_ack) begin
      stall_cnt <= stall_to ? '0 : stall_cnt + 1'b1;
      if (stall_to)
        seq_err_q <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

  assign bus.seq_err = seq_err_q;
`else
  assign stall_to    = 1'b0;
  assign bus.seq_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:   state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.instr_valid && op == OP_HALT)      state_nxt = ST_HALTED;
        else if (bus.instr_valid && op == OP_LOAD) state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (bus.mem_ack)   state_nxt = ST_RUN;
        else if (stall_to) state_nxt = ST_HALTED;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RST;
    endcase
  end

  // target stays 0 unless a strobe is raised in the same branch of logic.
  always_comb begin
    pc_init_c   = 1'b0;
    jump_en_c   = 1'b0;
    branch_en_c = 1'b0;
    halt_c      = 1'b0;
    mem_req_c   = 1'b0;
    target_c    = '0;
    retire      = 1'b0;
    case (state)
      ST_RST: begin
        pc_init_c = 1'b1;
        halt_c    = 1'b1;
      end
      ST_RUN: begin
        if (!bus.instr_valid) begin
          halt_c = 1'b1;
        end else begin
          case (op)
            OP_HALT: begin
              halt_c = 1'b1;
              retire = 1'b1;
            end
            OP_JUMP: begin
              jump_en_c = 1'b1;
              target_c  = bus.jmp_addr;
              retire    = 1'b1;
            end
            OP_BRANCH: begin
              if (bus.zero_flag) begin
                branch_en_c = 1'b1;
                target_c    = branch_target(bus.pc, bus.br_offset);
              end
              retire = 1'b1;
            end
            OP_LOAD: begin
              mem_req_c = 1'b1;
              halt_c    = 1'b1;
            end
            default: retire = 1'b1;
          endcase
        end
      end
      ST_STALL: begin
        mem_req_c = 1'b1;
        halt_c    = !bus.mem_ack;
        retire    = bus.mem_ack;
      end
      ST_HALTED: halt_c = 1'b1;
      default: begin
        pc_init_c = 1'b1;
        halt_c    = 1'b1;
      end
    endcase
  end

  assign bus.pc_init   = pc_init_c;
  assign bus.jump_en   = jump_en_c;
  assign bus.branch_en = branch_en_c;
  assign bus.halt      = halt_c;
  assign bus.mem_req   = mem_req_c;
  assign bus.target    = target_c;

  sat_counter #(.W(RETIRE_W)) u_retired (
    .clk (CLK),
    .clr (!init_n),
    .inc (retire),
    .q   (bus.retired)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer (narrow retire counter)
module tb_pc_sequencer;

  localparam int RW = 4;
  localparam logic [RW-1:0] RMAX = '1;

  // {pc_init, jump_en, branch_en, halt, mem_req}
  localparam logic [4:0] C_RST  = 5'b10010;
  localparam logic [4:0] C_BUB  = 5'b00010;
  localparam logic [4:0] C_J    = 5'b01000;
  localparam logic [4:0] C_B    = 5'b00100;
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LD   = 5'b00011;
  localparam logic [4:0] C_ACK  = 5'b00001;

  typedef struct {
    string          tag;
    logic [4:0]     ctl;
    logic [9:0]     tg;
    logic [RW-1:0]  ret;
    logic           err;
  } exp_t;

  logic clk = 1'b0;
  logic init_n;
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] mret = '0;
  logic mseq = 1'b0;
  exp_t sbq[$];

  pc_sequencer_if #(.RETIRE_W(RW)) bus ();

  pc_sequencer #(.STALL_TIMEOUT(16), .RETIRE_W(RW)) dut (
    .CLK    (clk),
    .init_n (init_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ops = {instr_valid, op_halt, op_jump, op_branch, op_load}
  task automatic step(input string tag, input logic rn, input logic [4:0] ops, input logic z,
                      input logic [9:0] ja, input logic [7:0] bo, input logic [9:0] p,
                      input logic ack, input logic [4:0] ctl, input logic [9:0] tg, input logic r);
    exp_t e;
    exp_t g;
    logic [4:0] obs;
    init_n          = rn;
    bus.instr_valid = ops[4];
    bus.op_halt     = ops[3];
    bus.op_jump     = ops[2];
    bus.op_branch   = ops[1];
    bus.op_load     = ops[0];
    bus.zero_flag   = z;
    bus.jmp_addr    = ja;
    bus.br_offset   = bo;
    bus.pc          = p;
    bus.mem_ack     = ack;
    e.tag = tag; e.ctl = ctl; e.tg = tg; e.ret = mret; e.err = mseq;
    sbq.push_back(e);
    #1;
    g = sbq.pop_front();
    obs = {bus.pc_init, bus.jump_en, bus.branch_en, bus.halt, bus.mem_req};
    checks++;
    assert (obs === g.ctl) else begin
      errors++;
      $error("FAIL %s ctl observed %b expected %b", g.tag, obs, g.ctl);
    end
    checks++;
    assert (bus.target === g.tg) else begin
      errors++;
      $error("FAIL %s target observed %h expected %h", g.tag, bus.target, g.tg);
    end
    checks++;
    assert (bus.retired === g.ret) else begin
      errors++;
      $error("FAIL %s retired observed %0d expected %0d", g.tag, bus.retired, g.ret);
    end
    checks++;
    assert (bus.seq_err === g.err) else begin
      errors++;
      $error("FAIL %s seq_err observed %b expected %b", g.tag, bus.seq_err, g.err);
    end
    if (!rn) begin
      mret = '0;
      mseq = 1'b0;
    end else if (r && mret != RMAX) begin
      mret = mret + 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    init_n = 1'b0;
    bus.instr_valid = 0; bus.op_halt = 0; bus.op_jump = 0; bus.op_branch = 0;
    bus.op_load = 0; bus.zero_flag = 0; bus.jmp_addr = '0; bus.br_offset = '0;
    bus.pc = '0; bus.mem_ack = 0;
    @(negedge clk);

    step("rst_hold", 0, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_RST, 10'h000, 0);
    step("rst_rel",  1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_RST, 10'h000, 0);
    step("run_bub",  1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_BUB, 10'h000, 0);

    step("br_wrap",  1, 5'b10010, 1, 10'h000, 8'h04, 10'h3FE, 0, C_B,    10'h002, 1);
    step("br_not",   1, 5'b10010, 0, 10'h000, 8'h04, 10'h3FE, 0, C_NONE, 10'h000, 1);
    step("jmp_pri",  1, 5'b10110, 1, 10'h004, 8'h04, 10'h3FE, 0, C_J,    10'h004, 1);
    step("br_neg",   1, 5'b10010, 1, 10'h000, 8'hFC, 10'h001, 0, C_B,    10'h3FD, 1);
    step("plain",    1, 5'b10000, 1, 10'h155, 8'h7F, 10'h100, 1, C_NONE, 10'h000, 1);

    step("ld",       1, 5'b10001, 0, 10'h000, 8'h00, 10'h000, 0, C_LD, 10'h000, 0);
    for (int i = 0; i < 3; i++)
      step("stall",  1, 5'b10100, 0, 10'h004, 8'h00, 10'h000, 0, C_LD, 10'h000, 0);
    step("ack",      1, 5'b10100, 0, 10'h004, 8'h00, 10'h000, 1, C_ACK, 10'h000, 1);
    step("ack_run",  1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 1, C_BUB, 10'h000, 0);

    step("ld2",      1, 5'b10001, 0, 10'h000, 8'h00, 10'h000, 0, C_LD,  10'h000, 0);
    step("stall2",   1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_LD,  10'h000, 0);
    step("rst_stl",  0, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_LD,  10'h000, 0);
    step("rst_out",  1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_RST, 10'h000, 0);
    step("run2",     1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_BUB, 10'h000, 0);

    step("ld_to",    1, 5'b10001, 0, 10'h000, 8'h00, 10'h000, 0, C_LD, 10'h000, 0);
`ifdef PC_SEQ_TIMEOUT_EN
    for (int i = 0; i < 16; i++)
      step("stall_to", 1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_LD, 10'h000, 0);
    mseq = 1'b1;
    step("to_halt",  1, 5'b10100, 0, 10'h004, 8'h00, 10'h000, 1, C_BUB, 10'h000, 0);
`else
    for (int i = 0; i < 20; i++)
      step("stall_wt", 1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_LD, 10'h000, 0);
    step("ack_late", 1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 1, C_ACK, 10'h000, 1);
`endif
    step("rst3",     0, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_BUB, 10'h000, 0);
    step("rst3_out", 1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_RST, 10'h000, 0);

    step("halt",     1, 5'b11110, 1, 10'h004, 8'h04, 10'h000, 0, C_BUB, 10'h000, 1);
    step("hlt_jmp",  1, 5'b10100, 0, 10'h004, 8'h00, 10'h000, 0, C_BUB, 10'h000, 0);
    step("hlt_ld",   1, 5'b10001, 0, 10'h000, 8'h00, 10'h000, 1, C_BUB, 10'h000, 0);
    step("hlt_br",   1, 5'b10010, 1, 10'h000, 8'h04, 10'h010, 0, C_BUB, 10'h000, 0);
    step("rst4",     0, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_BUB, 10'h000, 0);
    step("rst4_out", 1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_RST, 10'h000, 0);

    for (int i = 0; i < 14; i++)
      step("pre_sat", 1, 5'b10000, 0, 10'h000, 8'h00, 10'h000, 0, C_NONE, 10'h000, 1);
    for (int i = 0; i < 3; i++)
      step("sat",     1, 5'b10000, 0, 10'h000, 8'h00, 10'h000, 0, C_NONE, 10'h000, 1);
    step("sat_hold", 1, 5'b00000, 0, 10'h000, 8'h00, 10'h000, 0, C_BUB, 10'h000, 0);
    checks++;
    assert (bus.retired === RMAX) else begin
      errors++;
      $error("FAIL sat_final retired observed %0d expected %0d", bus.retired, RMAX);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
